// File: rtl/unpack_data_if.sv
// Packet-in / PIPE-beat-out bundle for unpack_data, plus the shared link-rate type.
typedef enum logic [2:0] {
  RATE_GEN1 = 3'd0,
  RATE_GEN2 = 3'd1,
  RATE_GEN3 = 3'd2,
  RATE_GEN4 = 3'd3,
  RATE_GEN5 = 3'd4
} rate_speed_e;

interface unpack_data_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_NUM_LANES = 4,
  parameter int PKT_BYTES     = 64
);
  logic [PKT_BYTES*8-1:0]              pkt_data_i;
  logic [PKT_BYTES-1:0]                pkt_k_i;
  logic [1:0]                          pkt_sync_header_i;
  logic [6:0]                          pkt_byte_cnt_i;
  logic                                pkt_valid_i;
  logic                                pkt_ready_o;
  logic [MAX_NUM_LANES*DATA_WIDTH-1:0] data_o;
  logic [MAX_NUM_LANES-1:0]            data_valid_o;
  logic [4*MAX_NUM_LANES-1:0]          data_k_o;
  logic [2*MAX_NUM_LANES-1:0]          sync_header_o;
  logic                                tx_ready_i;
  logic                                beat_last_o;

  // master: TX framing side plus the downstream consumer; slave: the unpacker
  modport master (
    output pkt_data_i, pkt_k_i, pkt_sync_header_i, pkt_byte_cnt_i, pkt_valid_i, tx_ready_i,
    input  pkt_ready_o, data_o, data_valid_o, data_k_o, sync_header_o, beat_last_o
  );
  modport slave (
    input  pkt_data_i, pkt_k_i, pkt_sync_header_i, pkt_byte_cnt_i, pkt_valid_i, tx_ready_i,
    output pkt_ready_o, data_o, data_valid_o, data_k_o, sync_header_o, beat_last_o
  );
endinterface

// File: rtl/unpack_data.sv
// Slices one buffered TLP/DLLP into per-cycle PIPE beats sized by lane count and PIPE width.
// Optional UNPACK_STATS_EN adds packet and beat counters.
module unpack_data #(
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_NUM_LANES = 4,
  parameter int PKT_BYTES     = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        phy_link_up_i,
  input  rate_speed_e curr_data_rate_i,
  input  logic [5:0]  pipe_width_i,
  input  logic [5:0]  num_active_lanes_i,
`ifdef UNPACK_STATS_EN
  output logic [15:0] pkt_count_o,
  output logic [31:0] beat_count_o,
`endif
  unpack_data_if.slave bus
);
  localparam int OUT_BYTES = MAX_NUM_LANES * DATA_WIDTH / 8;

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_LAST} state_e;

  state_e                   state_p1, state_nxt;
  logic [PKT_BYTES*8-1:0]   buf_p1, buf_nxt;
  logic [PKT_BYTES-1:0]     kbuf_p1, kbuf_nxt;
  logic [1:0]               hdr_p1, hdr_nxt;
  logic [6:0]               rem_p1, rem_nxt;
  logic [6:0]               bpb_p1, bpb_nxt;
  logic [MAX_NUM_LANES-1:0] mask_p1, mask_nxt;
  logic                     blk_p1, blk_nxt;

  logic [6:0] bpb_now;
  logic [6:0] cnt_clip;
  logic       ready;
  logic       accept;

  // Bytes per beat; zero for non-power-of-two lane counts, which blocks acceptance.
  function automatic logic [6:0] calc_bpb(input logic [5:0] pw, input logic [5:0] nl);
    int b;
    b = 0;
    for (int i = 0; i < 6; i++)
      if (nl == 6'(1 << i)) b = int'(pw >> 3) << i;
    if (b > OUT_BYTES) b = OUT_BYTES;
    return 7'(b);
  endfunction

  function automatic logic [MAX_NUM_LANES-1:0] calc_mask(input logic [5:0] nl);
    logic [MAX_NUM_LANES-1:0] m;
    for (int l = 0; l < MAX_NUM_LANES; l++) m[l] = (l < int'(nl));
    return m;
  endfunction

  assign bpb_now  = calc_bpb(pipe_width_i, num_active_lanes_i);
  assign cnt_clip = (bus.pkt_byte_cnt_i > 7'(PKT_BYTES)) ? 7'(PKT_BYTES) : bus.pkt_byte_cnt_i;

  // Ready in the last-beat cycle lets the next packet load with no bubble.
  always_comb begin
    ready = 1'b0;
    if (rst_ni && phy_link_up_i && bpb_now != 7'd0)
      ready = (state_p1 == ST_IDLE) || (state_p1 == ST_LAST && bus.tx_ready_i);
  end

  assign bus.pkt_ready_o = ready;
  assign accept          = bus.pkt_valid_i && ready;

  always_comb begin
    state_nxt = state_p1;
    buf_nxt   = buf_p1;
    kbuf_nxt  = kbuf_p1;
    hdr_nxt   = hdr_p1;
    rem_nxt   = rem_p1;
    bpb_nxt   = bpb_p1;
    mask_nxt  = mask_p1;
    blk_nxt   = blk_p1;
    if (!phy_link_up_i) begin
      state_nxt = ST_IDLE;
    end else begin
      if (state_p1 == ST_SEND && bus.tx_ready_i) begin
        buf_nxt   = buf_p1 >> {bpb_p1, 3'b000};
        kbuf_nxt  = kbuf_p1 >> bpb_p1;
        rem_nxt   = rem_p1 - bpb_p1;
        state_nxt = (rem_nxt <= bpb_p1) ? ST_LAST : ST_SEND;
      end
      if (state_p1 == ST_LAST && bus.tx_ready_i)
        state_nxt = ST_IDLE;
      if (accept) begin
        state_nxt = ST_IDLE;
        if (cnt_clip != 7'd0) begin
          buf_nxt   = bus.pkt_data_i;
          kbuf_nxt  = bus.pkt_k_i;
          hdr_nxt   = bus.pkt_sync_header_i;
          rem_nxt   = cnt_clip;
          bpb_nxt   = bpb_now;
          mask_nxt  = calc_mask(num_active_lanes_i);
          blk_nxt   = curr_data_rate_i inside {RATE_GEN3, RATE_GEN4, RATE_GEN5};
          state_nxt = (cnt_clip <= bpb_now) ? ST_LAST : ST_SEND;
        end
      end
    end
  end

  // Stage p1: control state and packet buffer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_p1 <= ST_IDLE;
      rem_p1   <= '0;
      bpb_p1   <= '0;
      mask_p1  <= '0;
      blk_p1   <= 1'b0;
    end else begin
      state_p1 <= state_nxt;
      rem_p1   <= rem_nxt;
      bpb_p1   <= bpb_nxt;
      mask_p1  <= mask_nxt;
      blk_p1   <= blk_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    buf_p1  <= buf_nxt;
    kbuf_p1 <= kbuf_nxt;
    hdr_p1  <= hdr_nxt;
  end

  // Beat view: the buffer is kept shifted so the current beat always starts at byte 0.
  always_comb begin
    bus.data_o        = '0;
    bus.data_k_o      = '0;
    bus.data_valid_o  = '0;
    bus.sync_header_o = '0;
    bus.beat_last_o   = 1'b0;
    if (state_p1 != ST_IDLE) begin
      bus.data_valid_o = mask_p1;
      bus.beat_last_o  = (state_p1 == ST_LAST);
      for (int b = 0; b < OUT_BYTES; b++) begin
        if (7'(b) < bpb_p1) begin
          if (7'(b) < rem_p1) begin
            bus.data_o[b*8 +: 8] = buf_p1[b*8 +: 8];
            bus.data_k_o[b]      = kbuf_p1[b];
          end else if (!blk_p1) begin
            bus.data_o[b*8 +: 8] = 8'hF7;
            bus.data_k_o[b]      = 1'b1;
          end
        end
      end
      for (int l = 0; l < MAX_NUM_LANES; l++)
        if (blk_p1 && mask_p1[l]) bus.sync_header_o[2*l +: 2] = hdr_p1;
    end
  end

`ifdef UNPACK_STATS_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pkt_count_o  <= '0;
      beat_count_o <= '0;
    end else begin
      if (accept && cnt_clip != 7'd0) pkt_count_o <= pkt_count_o + 16'd1;
      if (state_p1 != ST_IDLE && bus.tx_ready_i) beat_count_o <= beat_count_o + 32'd1;
    end
  end
`endif

endmodule
